// File: rtl/exp16_issue_buffer_if.sv
// Handshake bundle for the FP16 exp issue buffer: producer side, exp pipeline side,
// consumer side and status. The slave modport is the buffer's view; master is the environment's view.
interface exp16_issue_buffer_if #(
    parameter int DW    = 16,
    parameter int TW    = 8,
    parameter int DEPTH = 8
);
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [DW-1:0]           s_x_i;
    logic [TW-1:0]           s_tag_i;
    logic                    s_last_i;
    logic                    exp_valid_o;
    logic [DW-1:0]           exp_x_o;
    logic                    exp_valid_i;
    logic [DW-1:0]           exp_y_i;
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic [DW-1:0]           m_y_o;
    logic [TW-1:0]           m_tag_o;
    logic                    m_last_o;
    logic [$clog2(DEPTH):0]  occ_o;
    logic                    busy_o;
    logic                    err_align_o;

    modport slave (
        input  s_valid_i, s_x_i, s_tag_i, s_last_i, exp_valid_i, exp_y_i, m_ready_i,
        output s_ready_o, exp_valid_o, exp_x_o, m_valid_o, m_y_o, m_tag_o, m_last_o,
               occ_o, busy_o, err_align_o
    );

    modport master (
        output s_valid_i, s_x_i, s_tag_i, s_last_i, exp_valid_i, exp_y_i, m_ready_i,
        input  s_ready_o, exp_valid_o, exp_x_o, m_valid_o, m_y_o, m_tag_o, m_last_o,
               occ_o, busy_o, err_align_o
    );
endinterface

// File: rtl/exp16_issue_buffer.sv
// Credit-based issue buffer around a fixed-latency, non-stallable FP16 exp pipeline:
// operands issue only when a result slot is guaranteed; tag/last ride a matched delay line.
module exp16_issue_buffer #(
    parameter int DW      = 16,
    parameter int TW      = 8,
    parameter int DEPTH   = 8,
    parameter int LAT_EXP = 40
) (
    input  logic                  clk,
    input  logic                  rstn,
    exp16_issue_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int MW = $clog2(LAT_EXP + 1);

    localparam logic [OW-1:0] DEPTH_C  = OW'(DEPTH);
    localparam logic [OW-1:0] ONE_O    = OW'(1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [MW-1:0] MASK_END = MW'(LAT_EXP);
    localparam logic [MW-1:0] ONE_M    = MW'(1);

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic          last;
    } side_t;

    typedef struct packed {
        logic [DW-1:0] y;
        logic [TW-1:0] tag;
        logic          last;
    } entry_t;

    side_t         dline [LAT_EXP];
    entry_t        mem   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] inflight;
    logic [OW-1:0] fifo_cnt;
    logic [OW-1:0] occ;
    logic [OW-1:0] inflight_n;
    logic [OW-1:0] fifo_cnt_n;
    logic [MW-1:0] mask_cnt;
    logic          err_align;

    side_t  dout;
    logic   accept;
    logic   wr;
    logic   pop;
    logic   m_valid;
    logic   mask_active;

    // Credit comes from the registered occupancy only, so ready never loops through valid.
    assign bus.s_ready_o = (occ < DEPTH_C);
    assign accept        = bus.s_valid_i & bus.s_ready_o;

    assign bus.exp_valid_o = accept;
    assign bus.exp_x_o     = bus.s_x_i;

    assign dout        = dline[LAT_EXP-1];
    assign wr          = dout.valid;
    assign m_valid     = (fifo_cnt != '0);
    assign pop         = m_valid & bus.m_ready_i;
    assign mask_active = (mask_cnt != MASK_END);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT_EXP; i++) dline[i] <= '0;
        end else begin
            dline[0] <= '{valid: accept, tag: bus.s_tag_i, last: bus.s_last_i};
            for (int i = 1; i < LAT_EXP; i++) dline[i] <= dline[i-1];
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        inflight_n = inflight;
        fifo_cnt_n = fifo_cnt;
        if (accept && !wr)      inflight_n = inflight + ONE_O;
        else if (!accept && wr) inflight_n = inflight - ONE_O;
        if (wr && !pop)         fifo_cnt_n = fifo_cnt + ONE_O;
        else if (!wr && pop)    fifo_cnt_n = fifo_cnt - ONE_O;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight  <= '0;
            fifo_cnt  <= '0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mask_cnt  <= '0;
            err_align <= 1'b0;
        end else begin
            inflight <= inflight_n;
            fifo_cnt <= fifo_cnt_n;
            occ      <= inflight_n + fifo_cnt_n;
            if (wr)  wr_ptr <= wr_ptr + ONE_A;
            if (pop) rd_ptr <= rd_ptr + ONE_A;
            if (mask_active) mask_cnt <= mask_cnt + ONE_M;
            // Stale pipeline outputs after reset are ignored until the mask expires.
            if (!mask_active && (dout.valid != bus.exp_valid_i)) err_align <= 1'b1;
        end
    end

    // NOTE: result storage is deliberately not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= '{y: bus.exp_y_i, tag: dout.tag, last: dout.last};
    end

    always_ff @(posedge clk) begin
        if (rstn) assert (!(wr && fifo_cnt == DEPTH_C));
    end

    assign bus.m_valid_o   = m_valid;
    assign bus.m_y_o       = mem[rd_ptr].y;
    assign bus.m_tag_o     = mem[rd_ptr].tag;
    assign bus.m_last_o    = mem[rd_ptr].last;
    assign bus.occ_o       = occ;
    assign bus.busy_o      = (occ != '0);
    assign bus.err_align_o = err_align;
endmodule

// File: tb/tb_exp16_issue_buffer.sv
// Self-checking bench for exp16_issue_buffer with LAT_EXP=4, DEPTH=8 and a behavioural
// exp pipeline (y = x ^ 16'h5A5A) whose valid can be overridden to inject misalignment.
module tb_exp16_issue_buffer;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    exp16_issue_buffer_if #(.DW(16), .TW(8), .DEPTH(DEPTH)) bus ();

    exp16_issue_buffer #(.DW(16), .TW(8), .DEPTH(DEPTH), .LAT_EXP(LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural exp pipeline; valid can be forced to model a late result.
    logic        pipe_v [LAT];
    logic [15:0] pipe_y [LAT];
    logic        vmode = 1'b0;
    logic        v_ovr = 1'b0;

    always @(posedge clk) begin
        pipe_v[0] <= bus.exp_valid_o;
        pipe_y[0] <= bus.exp_x_o ^ 16'h5A5A;
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end

    assign bus.exp_valid_i = vmode ? v_ovr : pipe_v[LAT-1];
    assign bus.exp_y_i     = pipe_y[LAT-1];

    logic [3:0] max_occ = '0;
    always @(negedge clk) if (rstn && bus.occ_o > max_occ) max_occ <= bus.occ_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        sv;
        logic [15:0] x;
        logic [7:0]  tag;
        logic        last;
        logic        e_exp_v;
        logic        e_s_ready;
        logic        e_m_valid;
        logic [15:0] e_y;
        logic [7:0]  e_tag;
        logic        e_last;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int accepts;
        int sent;
        int rcvd;
        int budget;
        logic [15:0] xr;

        vecs[0] = '{1'b1, 16'h3C01, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd0};
        vecs[1] = '{1'b1, 16'h3C02, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd1};
        vecs[2] = '{1'b1, 16'h3C03, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd2};
        vecs[3] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd3};
        vecs[4] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd3};
        vecs[5] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h665B, 8'd1, 1'b0, 4'd3};
        vecs[6] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6658, 8'd2, 1'b0, 4'd2};
        vecs[7] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6659, 8'd3, 1'b1, 4'd1};
        vecs[8] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 4'd0};

        bus.s_valid_i = 1'b0;
        bus.s_x_i     = '0;
        bus.s_tag_i   = '0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b0;

        // Reset state
        repeat (5) tick();
        check("rst_s_ready", bus.s_ready_o, 1);
        check("rst_m_valid", bus.m_valid_o, 0);
        check("rst_exp_valid", bus.exp_valid_o, 0);
        check("rst_occ", bus.occ_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_align_o, 0);
        rstn = 1'b1;
        repeat (9) tick();

        // Three back-to-back operands, consumer always ready
        for (int i = 0; i < 9; i++) begin
            tick();
            bus.s_valid_i = vecs[i].sv;
            bus.s_x_i     = vecs[i].x;
            bus.s_tag_i   = vecs[i].tag;
            bus.s_last_i  = vecs[i].last;
            bus.m_ready_i = 1'b1;
            #1;
            check($sformatf("v%0d_exp_valid", i), bus.exp_valid_o, vecs[i].e_exp_v);
            if (vecs[i].e_exp_v) check($sformatf("v%0d_exp_x", i), bus.exp_x_o, vecs[i].x);
            check($sformatf("v%0d_s_ready", i), bus.s_ready_o, vecs[i].e_s_ready);
            check($sformatf("v%0d_m_valid", i), bus.m_valid_o, vecs[i].e_m_valid);
            check($sformatf("v%0d_occ", i), bus.occ_o, vecs[i].e_occ);
            if (vecs[i].e_m_valid) begin
                check($sformatf("v%0d_m_y", i), bus.m_y_o, vecs[i].e_y);
                check($sformatf("v%0d_m_tag", i), bus.m_tag_o, vecs[i].e_tag);
                check($sformatf("v%0d_m_last", i), bus.m_last_o, vecs[i].e_last);
            end
        end
        check("t1_err", bus.err_align_o, 0);

        // Fill to credit limit with the consumer stalled
        bus.m_ready_i = 1'b0;
        accepts = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            bus.s_valid_i = 1'b1;
            bus.s_x_i     = 16'h1000 + 16'(10 + accepts);
            bus.s_tag_i   = 8'(10 + accepts);
            bus.s_last_i  = 1'b0;
            #1;
            if (c == 7) check("t2_ready_c7", bus.s_ready_o, 1);
            if (c == 8) check("t2_ready_c8", bus.s_ready_o, 0);
            if (bus.s_ready_o) accepts++;
        end
        check("t2_accepts", accepts, 8);
        check("t2_occ_full", bus.occ_o, 8);
        check("t2_m_valid_full", bus.m_valid_o, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.s_valid_i = 1'b0;
            bus.m_ready_i = 1'b1;
            #1;
            check($sformatf("t2_pop%0d_valid", i), bus.m_valid_o, 1);
            check($sformatf("t2_pop%0d_tag", i), bus.m_tag_o, 10 + i);
            check($sformatf("t2_pop%0d_y", i), bus.m_y_o, (16'h1000 + 16'(10 + i)) ^ 16'h5A5A);
            if (i == 0) check("t2_ready_first_pop", bus.s_ready_o, 0);
            if (i == 1) check("t2_ready_after_pop", bus.s_ready_o, 1);
        end
        tick();
        bus.m_ready_i = 1'b0;
        #1;
        check("t2_drained_valid", bus.m_valid_o, 0);
        check("t2_drained_occ", bus.occ_o, 0);

        // One result returned a cycle late by the pipeline
        vmode = 1'b1;
        v_ovr = 1'b0;
        tick();
        bus.s_valid_i = 1'b1;
        bus.s_x_i     = 16'h2222;
        bus.s_tag_i   = 8'h40;
        bus.s_last_i  = 1'b1;
        #1;
        check("t3_accept", bus.s_ready_o, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.s_valid_i = 1'b0;
            v_ovr = (k == 5);
            #1;
            if (k == 4) check("t3_err_before", bus.err_align_o, 0);
            if (k == 5) begin
                check("t3_err_set", bus.err_align_o, 1);
                check("t3_m_valid", bus.m_valid_o, 1);
                check("t3_occ", bus.occ_o, 1);
            end
        end
        vmode = 1'b0;
        check("t3_m_tag", bus.m_tag_o, 8'h40);
        check("t3_m_y", bus.m_y_o, 16'h7878);
        check("t3_m_last", bus.m_last_o, 1);
        tick();
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i = 1'b0;
        #1;
        check("t3_occ_after", bus.occ_o, 0);
        check("t3_err_sticky", bus.err_align_o, 1);

        // Reset mid-stream, then stale pipeline valids inside the mask window
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.s_valid_i = 1'b1;
            bus.s_x_i     = 16'h3000 + 16'(i);
            bus.s_tag_i   = 8'(i);
            bus.s_last_i  = 1'b0;
        end
        tick();
        bus.s_valid_i = 1'b0;
        #1;
        check("t4_occ_before", bus.occ_o, 5);
        vmode = 1'b1;
        v_ovr = 1'b0;
        rstn  = 1'b0;
        #1;
        check("t4_rst_s_ready", bus.s_ready_o, 1);
        check("t4_rst_m_valid", bus.m_valid_o, 0);
        check("t4_rst_occ", bus.occ_o, 0);
        check("t4_rst_busy", bus.busy_o, 0);
        check("t4_rst_err", bus.err_align_o, 0);
        check("t4_rst_exp_valid", bus.exp_valid_o, 0);
        repeat (2) tick();
        rstn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            v_ovr = (k == 1 || k == 2);
            #1;
            check($sformatf("t4_k%0d_m_valid", k), bus.m_valid_o, 0);
            check($sformatf("t4_k%0d_err", k), bus.err_align_o, 0);
        end
        v_ovr = 1'b0;
        vmode = 1'b0;
        check("t4_occ_after", bus.occ_o, 0);

        // Random consumer backpressure, 1000 operands
        sent   = 0;
        rcvd   = 0;
        budget = 0;
        while ((sent < 1000 || rcvd < 1000) && budget < 20000) begin
            tick();
            bus.s_valid_i = (sent < 1000);
            bus.s_x_i     = 16'(sent * 37 + 5);
            bus.s_tag_i   = 8'(sent);
            bus.s_last_i  = ((sent % 16) == 15);
            bus.m_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (bus.s_valid_i && bus.s_ready_o) sent++;
            if (bus.m_valid_o && bus.m_ready_i) begin
                xr = 16'(rcvd * 37 + 5) ^ 16'h5A5A;
                check($sformatf("t5_pop%0d", rcvd), {bus.m_tag_o, bus.m_y_o, bus.m_last_o},
                      {8'(rcvd), xr, ((rcvd % 16) == 15)});
                rcvd++;
            end
            budget++;
        end
        check("t5_received", rcvd, 1000);
        check("t5_err", bus.err_align_o, 0);
        check("t5_max_occ_le_depth", (max_occ <= 4'(DEPTH)), 1);
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
